// File: rtl/dsiq_txbuffer.sv
// dsiq_txbuffer: packs the PC->card TX IQ byte stream into {I,Q} words, buffers them
// in a first-word-fall-through FIFO and streams them out with prefill/underflow control.
module dsiq_txbuffer #(
  parameter int DEPTH_LOG2 = 10,
  parameter int PREFILL    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [7:0]            s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic [31:0]           m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  streaming,
  output logic                  underflow,
  output logic                  framing_err,
  output logic [15:0]           ovf_cnt
);
  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PREFILL_W = PREFILL[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] PTR_ZERO  = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0] PTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_FILL = 1'b0, ST_STREAM = 1'b1} state_t;

  state_t              r_state;
  logic [1:0]          r_bidx;
  logic [23:0]         r_hold;
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;
  logic [31:0]         r_mem [DEPTH];
  logic [31:0]         r_m_tdata;
  logic                r_m_tvalid;
  logic [DEPTH_LOG2:0] r_fill;
  logic                r_streaming;
  logic                r_underflow;
  logic                r_framing_err;
  logic [15:0]         r_ovf_cnt;

  state_t              w_state_nxt;
  logic [1:0]          w_bidx_nxt;
  logic [23:0]         w_hold_nxt;
  logic [DEPTH_LOG2:0] w_wptr_nxt;
  logic [DEPTH_LOG2:0] w_rptr_nxt;
  logic [DEPTH_LOG2:0] w_fill_nxt;
  logic [31:0]         w_word;
  logic [31:0]         w_head;
  logic                w_push_req;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_ferr;
  logic                w_uflow;
  logic                w_tvalid_nxt;

  assign w_word  = {r_hold, s_tdata};
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                   (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);

  // Byte assembly, framing checks, FIFO pointer and output-state next values
  always_comb begin
    w_push_req = 1'b0;
    w_ferr     = 1'b0;
    w_bidx_nxt = r_bidx;
    w_hold_nxt = r_hold;
    if (s_tvalid) begin
      if (r_bidx == 2'd3) begin
        w_push_req = 1'b1;
        w_ferr     = ~s_tlast;
        w_bidx_nxt = 2'd0;
      end else if (s_tlast) begin
        w_ferr     = 1'b1;
        w_bidx_nxt = 2'd0;
        w_hold_nxt = 24'd0;
      end else begin
        w_bidx_nxt = r_bidx + 2'd1;
        w_hold_nxt = {r_hold[15:0], s_tdata};
      end
    end else begin
      w_bidx_nxt = r_bidx;
    end

    w_push = w_push_req & ~w_full & ~flush;
    w_drop = w_push_req & w_full & ~flush;
    w_pop  = r_m_tvalid & m_tready & ~flush;

    w_state_nxt = r_state;
    w_uflow     = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (r_fill >= PREFILL_W) w_state_nxt = ST_STREAM;
        else                     w_state_nxt = ST_FILL;
      end
      ST_STREAM: begin
        if (w_empty && m_tready) begin
          w_state_nxt = ST_FILL;
          w_uflow     = 1'b1;
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase

    if (flush) begin
      w_state_nxt = ST_FILL;
      w_uflow     = 1'b0;
      w_ferr      = 1'b0;
      w_bidx_nxt  = 2'd0;
      w_hold_nxt  = 24'd0;
      w_wptr_nxt  = PTR_ZERO;
      w_rptr_nxt  = PTR_ZERO;
    end else begin
      w_wptr_nxt  = r_wptr + (w_push ? PTR_ONE : PTR_ZERO);
      w_rptr_nxt  = r_rptr + (w_pop  ? PTR_ONE : PTR_ZERO);
    end

    w_fill_nxt   = w_wptr_nxt - w_rptr_nxt;
    w_tvalid_nxt = (w_state_nxt == ST_STREAM) && (w_fill_nxt != PTR_ZERO);
    // A word written this cycle into an empty slot must bypass the memory read.
    if (w_push && (r_wptr == w_rptr_nxt)) w_head = w_word;
    else                                  w_head = r_mem[w_rptr_nxt[DEPTH_LOG2-1:0]];
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= w_word;
  end

  // State, pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FILL;
      r_bidx        <= 2'd0;
      r_hold        <= 24'd0;
      r_wptr        <= PTR_ZERO;
      r_rptr        <= PTR_ZERO;
      r_m_tdata     <= 32'd0;
      r_m_tvalid    <= 1'b0;
      r_fill        <= PTR_ZERO;
      r_streaming   <= 1'b0;
      r_underflow   <= 1'b0;
      r_framing_err <= 1'b0;
      r_ovf_cnt     <= 16'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_bidx        <= w_bidx_nxt;
      r_hold        <= w_hold_nxt;
      r_wptr        <= w_wptr_nxt;
      r_rptr        <= w_rptr_nxt;
      r_m_tdata     <= w_tvalid_nxt ? w_head : 32'd0;
      r_m_tvalid    <= w_tvalid_nxt;
      r_fill        <= w_fill_nxt;
      r_streaming   <= (w_state_nxt == ST_STREAM);
      r_underflow   <= w_uflow;
      r_framing_err <= w_ferr;
      if (w_drop && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
      else                                   r_ovf_cnt <= r_ovf_cnt;
    end
  end

  assign m_tdata     = r_m_tdata;
  assign m_tvalid    = r_m_tvalid;
  assign fill        = r_fill;
  assign streaming   = r_streaming;
  assign underflow   = r_underflow;
  assign framing_err = r_framing_err;
  assign ovf_cnt     = r_ovf_cnt;

endmodule

// File: tb/tb_dsiq_txbuffer.sv
// Self-checking bench for dsiq_txbuffer: byte-vector table, hand-written corner
// sequences and a word scoreboard checked at every output handshake.
module tb_dsiq_txbuffer;
  localparam int DL = 4;
  localparam int PF = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [7:0]    s_tdata = 8'd0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DL:0]   fill;
  logic          streaming;
  logic          underflow;
  logic          framing_err;
  logic [15:0]   ovf_cnt;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic        exp_ferr;
    logic [DL:0] exp_fill;
  } vec_t;
  vec_t vecs[10];

  dsiq_txbuffer #(.DEPTH_LOG2(DL), .PREFILL(PF)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .fill(fill), .streaming(streaming), .underflow(underflow),
    .framing_err(framing_err), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'd0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_out);
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], (b == 3));
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    m_tready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 32'd0);
    repeat (4) step();
  endtask

  function automatic logic [31:0] mkword(input int k);
    logic [7:0] kb;
    logic [7:0] k3;
    kb = k[7:0];
    k3 = kb * 8'd3;
    return {kb, 8'hA5, k3, 8'h5A};
  endfunction

  // Scoreboard: every handshake must deliver the oldest expected word; idle data must be zero
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got %h required no word", m_tdata);
      end else begin
        check("sb_word", m_tdata, exp_q.pop_front());
      end
    end else if (!m_tvalid) begin
      check("tdata_zero", m_tdata, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hAA, 1'b0, 1'b0, 5'd0};
    vecs[1] = '{8'hBB, 1'b1, 1'b1, 5'd0};
    vecs[2] = '{8'h01, 1'b0, 1'b0, 5'd0};
    vecs[3] = '{8'h02, 1'b0, 1'b0, 5'd0};
    vecs[4] = '{8'h03, 1'b0, 1'b0, 5'd0};
    vecs[5] = '{8'h04, 1'b1, 1'b0, 5'd1};
    vecs[6] = '{8'h05, 1'b0, 1'b0, 5'd1};
    vecs[7] = '{8'h06, 1'b0, 1'b0, 5'd1};
    vecs[8] = '{8'h07, 1'b0, 1'b0, 5'd1};
    vecs[9] = '{8'h08, 1'b0, 1'b1, 5'd2};

    // Reset values
    step(); step();
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_fill", {27'd0, fill}, 32'd0);
    check("rst_streaming", {31'd0, streaming}, 32'd0);
    check("rst_underflow", {31'd0, underflow}, 32'd0);
    check("rst_framing", {31'd0, framing_err}, 32'd0);
    check("rst_ovf", {16'd0, ovf_cnt}, 32'd0);
    rst_n = 1'b1;
    step();

    // Prefill of 4 samples, then back-to-back output and underflow
    m_tready = 1'b1;
    for (int k = 0; k < 4; k++) send_word({16'h1234 + 16'(k), 16'hABCD + 16'(k)}, 1'b1);
    check("pf_streaming_n1", {31'd0, streaming}, 32'd0);
    check("pf_fill_n1", {27'd0, fill}, 32'd4);
    step();
    check("pf_streaming_n2", {31'd0, streaming}, 32'd1);
    check("pf_tvalid_n2", {31'd0, m_tvalid}, 32'd1);
    check("pf_word0", m_tdata, 32'h1234ABCD);
    step(); check("pf_word1", m_tdata, 32'h1235ABCE);
    step(); check("pf_word2", m_tdata, 32'h1236ABCF);
    step(); check("pf_word3", m_tdata, 32'h1237ABD0);
    step();
    check("uf_tvalid_low", {31'd0, m_tvalid}, 32'd0);
    check("uf_tdata_zero", m_tdata, 32'd0);
    check("uf_not_yet", {31'd0, underflow}, 32'd0);
    step();
    check("uf_pulse", {31'd0, underflow}, 32'd1);
    check("uf_streaming_low", {31'd0, streaming}, 32'd0);
    step();
    check("uf_pulse_end", {31'd0, underflow}, 32'd0);

    // Framing rules, table driven
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send_byte(vecs[i].data, vecs[i].last);
      check($sformatf("frm_ferr_%0d", i), {31'd0, framing_err}, {31'd0, vecs[i].exp_ferr});
      check($sformatf("frm_fill_%0d", i), {27'd0, fill}, {27'd0, vecs[i].exp_fill});
    end
    step();
    check("frm_ferr_clear", {31'd0, framing_err}, 32'd0);

    // Flush discards them; then overflow with a stalled sink
    flush = 1'b1; step(); flush = 1'b0;
    check("flush1_fill", {27'd0, fill}, 32'd0);
    for (int k = 0; k < 20; k++) send_word(mkword(k), (k < 16));
    check("ovf_fill", {27'd0, fill}, 32'd16);
    check("ovf_cnt", {16'd0, ovf_cnt}, 32'd4);
    check("ovf_streaming", {31'd0, streaming}, 32'd1);
    drain("ovf_drain");
    check("ovf_after_drain_fill", {27'd0, fill}, 32'd0);

    // Flush mid-stream with fill=10 and two bytes of a partial word
    m_tready = 1'b0;
    for (int k = 0; k < 10; k++) send_word(mkword(100 + k), 1'b1);
    send_byte(8'h77, 1'b0);
    send_byte(8'h66, 1'b0);
    check("fl_fill_before", {27'd0, fill}, 32'd10);
    check("fl_streaming_before", {31'd0, streaming}, 32'd1);
    flush = 1'b1; step(); flush = 1'b0;
    exp_q.delete();
    check("fl_fill", {27'd0, fill}, 32'd0);
    check("fl_streaming", {31'd0, streaming}, 32'd0);
    check("fl_tvalid", {31'd0, m_tvalid}, 32'd0);
    send_word(32'hDEADBEEF, 1'b1);
    check("fl_clean_fill", {27'd0, fill}, 32'd1);
    check("fl_clean_ferr", {31'd0, framing_err}, 32'd0);
    for (int k = 0; k < 3; k++) send_word(mkword(200 + k), 1'b1);
    drain("fl_drain");
    check("fl_ovf_kept", {16'd0, ovf_cnt}, 32'd4);

    // Asynchronous reset between edges while streaming with a partial word
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(mkword(50 + k), 1'b1);
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    check("ar_streaming_before", {31'd0, streaming}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("ar_tdata", m_tdata, 32'd0);
    check("ar_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("ar_fill", {27'd0, fill}, 32'd0);
    check("ar_streaming", {31'd0, streaming}, 32'd0);
    check("ar_ovf", {16'd0, ovf_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    send_word(32'h11223344, 1'b1);
    check("ar_resume_fill", {27'd0, fill}, 32'd1);
    check("ar_resume_ferr", {31'd0, framing_err}, 32'd0);
    for (int k = 0; k < 3; k++) send_word(mkword(60 + k), 1'b1);
    drain("ar_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
